// File: rtl/peripheral_bcd2bin_if.sv
// rtl/peripheral_bcd2bin_if.sv - peripheral bus bundle for the BCD-to-binary converter
interface peripheral_bcd2bin_if;
    logic        cs;
    logic [4:2]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_in;
    logic [31:0] d_out;

    modport master (
        output cs,
        output addr,
        output rd,
        output wr,
        output d_in,
        input  d_out
    );

    modport slave (
        input  cs,
        input  addr,
        input  rd,
        input  wr,
        input  d_in,
        output d_out
    );
endinterface

// File: rtl/peripheral_bcd2bin.sv
// rtl/peripheral_bcd2bin.sv - 10-digit packed BCD to 32-bit binary, one digit per clock
module peripheral_bcd2bin #(
    parameter int unsigned clk_freq = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    peripheral_bcd2bin_if.slave bus
);
    if (clk_freq == 0) begin : g_bad_clk_freq
        $error("peripheral_bcd2bin: clk_freq must be non-zero");
    end

    localparam logic [2:0] A_BCD_LO = 3'b000;
    localparam logic [2:0] A_BCD_HI = 3'b001;
    localparam logic [2:0] A_CTRL   = 3'b010;
    localparam logic [2:0] A_STATUS = 3'b011;
    localparam logic [2:0] A_RESULT = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] bcd_lo;
    logic [7:0]  bcd_hi;
    logic [39:0] shreg;
    logic [33:0] acc;
    logic [3:0]  cnt;
    logic        inv_seen;
    logic        ready;
    logic        overflow;
    logic        invalid;
    logic [31:0] result;

    logic        wr_sel;
    logic        rd_sel;
    logic        start;
    logic        busy;
    logic [3:0]  digit;

    assign wr_sel = bus.cs & bus.wr;
    assign rd_sel = bus.cs & bus.rd;
    assign start  = wr_sel && (bus.addr == A_CTRL) && bus.d_in[0];
    assign busy   = (state != IDLE);
    assign digit  = shreg[39:36];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bcd_lo   <= '0;
            bcd_hi   <= '0;
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            inv_seen <= 1'b0;
            ready    <= 1'b0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
            result   <= '0;
        end else begin
            if (wr_sel && bus.addr == A_BCD_LO) bcd_lo <= bus.d_in;
            if (wr_sel && bus.addr == A_BCD_HI) bcd_hi <= bus.d_in[7:0];

            case (state)
                IDLE: begin
                    // Operands are snapshotted here; later register writes only affect the next run.
                    if (start) begin
                        shreg    <= {bcd_hi, bcd_lo};
                        acc      <= '0;
                        cnt      <= '0;
                        inv_seen <= 1'b0;
                        ready    <= 1'b0;
                        overflow <= 1'b0;
                        invalid  <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc   <= (acc << 3) + (acc << 1) + {30'd0, digit};
                    shreg <= {shreg[35:0], 4'h0};
                    if (digit > 4'd9) inv_seen <= 1'b1;
                    cnt   <= cnt + 4'd1;
                    if (cnt == 4'd9) state <= DONE;
                end
                DONE: begin
                    ready <= 1'b1;
                    if (inv_seen) begin
                        result   <= '0;
                        overflow <= 1'b0;
                        invalid  <= 1'b1;
                    end else begin
                        result   <= acc[31:0];
                        overflow <= |acc[33:32];
                        invalid  <= 1'b0;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read data reflects state before this edge's update, and is zero whenever not reading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.d_out <= '0;
        end else begin
            bus.d_out <= '0;
            if (rd_sel) begin
                case (bus.addr)
                    A_STATUS: bus.d_out <= {28'd0, invalid, overflow, busy, ready};
                    A_RESULT: bus.d_out <= result;
                    default:  bus.d_out <= '0;
                endcase
            end
        end
    end
endmodule
